// File: rtl/biu_multi.sv
// Bus interface unit: decodes CPU data accesses onto DMEM or one of NPERIPH peripherals,
// stretches peripheral accesses on pready with a timeout watchdog, and logs access errors.
module biu_multi #(
  parameter int          NPERIPH    = 4,
  parameter int          DMEM_AW    = 16,
  parameter logic [31:0] PBASE      = 32'h40000,
  parameter int          PSPAN_LOG2 = 4,
  parameter int          TIMEOUT    = 16,
  parameter logic [31:0] ERR_DATA   = 32'hDEADBEEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   dreq,
  input  logic [31:0]            daddr,
  input  logic [31:0]            dwdata,
  input  logic [3:0]             dwe,
  output logic [31:0]            drdata,
  output logic                   dstall,
  output logic [31:0]            daddr_m,
  output logic [31:0]            dwdata_m,
  output logic [3:0]             dwe_m,
  input  logic [31:0]            drdata_m,
  output logic [31:0]            paddr,
  output logic [31:0]            pwdata,
  output logic [NPERIPH-1:0]     psel,
  output logic [4*NPERIPH-1:0]   pwe,
  input  logic [32*NPERIPH-1:0]  prdata,
  input  logic [NPERIPH-1:0]     pready,
  input  logic                   err_clr,
  output logic                   err_valid,
  output logic [1:0]             err_cause,
  output logic [31:0]            err_addr,
  output logic [7:0]             err_count
);

  localparam int          IW         = (NPERIPH > 1) ? $clog2(NPERIPH) : 1;
  localparam logic [31:0] PBASE_PAGE = PBASE >> PSPAN_LOG2;
  localparam logic [7:0]  WLAST      = 8'(TIMEOUT - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t          r_state;
  logic [7:0]      r_wcnt;
  logic [IW-1:0]   r_tidx;
  logic            r_err_valid;
  logic [1:0]      r_err_cause;
  logic [31:0]     r_err_addr;
  logic [7:0]      r_err_count;

  logic [31:0]     w_page;
  logic            w_dmem_sel;
  logic            w_per_sel;
  logic [IW-1:0]   w_pidx;
  logic            w_prdy;
  logic [31:0]     w_prdata;
  logic            w_per_acc;
  logic            w_same_tgt;
  logic            w_abort;
  logic            w_unmapped;
  logic            w_err;
  logic [1:0]      w_cause;

  assign w_page     = daddr >> PSPAN_LOG2;
  assign w_dmem_sel = (daddr >> DMEM_AW) == 32'd0;

  // DMEM wins if a peripheral page were ever configured inside the DMEM window
  always_comb begin
    w_per_sel = 1'b0;
    w_pidx    = '0;
    w_prdy    = 1'b0;
    w_prdata  = '0;
    for (int i = 0; i < NPERIPH; i++) begin
      if (!w_dmem_sel && (w_page == PBASE_PAGE + 32'(i))) begin
        w_per_sel = 1'b1;
        w_pidx    = IW'(i);
        w_prdy    = pready[i];
        w_prdata  = prdata[32*i +: 32];
      end
    end
  end

  assign w_per_acc  = dreq && w_per_sel;
  assign w_same_tgt = (r_state == S_WAIT) && w_per_acc && (w_pidx == r_tidx);
  assign w_abort    = w_same_tgt && !w_prdy && (r_wcnt == WLAST);
  assign w_unmapped = dreq && !w_dmem_sel && !w_per_sel;
  assign w_err      = w_unmapped || w_abort;
  assign w_cause    = w_abort ? 2'b10 : 2'b01;

  assign daddr_m  = daddr;
  assign dwdata_m = dwdata;
  assign dwe_m    = (dreq && w_dmem_sel) ? dwe : 4'b0000;
  assign paddr    = daddr;
  assign pwdata   = dwdata;
  assign dstall   = !reset && w_per_acc && !w_prdy && !w_abort;

  always_comb begin
    psel = '0;
    pwe  = '0;
    for (int i = 0; i < NPERIPH; i++) begin
      if (w_per_acc && (w_pidx == IW'(i))) begin
        psel[i]       = 1'b1;
        pwe[4*i +: 4] = dwe;
      end
    end
  end

  always_comb begin
    drdata = drdata_m;
    if (dreq) begin
      if (w_per_sel)       drdata = w_abort ? ERR_DATA : w_prdata;
      else if (!w_dmem_sel) drdata = ERR_DATA;
    end
  end

  // Watchdog: r_wcnt counts stalled cycles of one continuing access to r_tidx
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_wcnt  <= 8'd0;
      r_tidx  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_per_acc && !w_prdy) begin
            r_state <= S_WAIT;
            r_wcnt  <= 8'd1;
            r_tidx  <= w_pidx;
          end
        end
        S_WAIT: begin
          if (!w_same_tgt || w_prdy || w_abort) begin
            r_state <= S_IDLE;
            r_wcnt  <= 8'd0;
          end else begin
            r_wcnt <= r_wcnt + 8'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_wcnt  <= 8'd0;
        end
      endcase
    end
  end

  // Clear beats a same-cycle error for the sticky fields, never for the counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_valid <= 1'b0;
      r_err_cause <= 2'b00;
      r_err_addr  <= 32'd0;
      r_err_count <= 8'd0;
    end else begin
      if (w_err && (r_err_count != 8'hFF)) r_err_count <= r_err_count + 8'd1;
      if (err_clr) begin
        r_err_valid <= 1'b0;
        r_err_cause <= 2'b00;
        r_err_addr  <= 32'd0;
      end else if (w_err && !r_err_valid) begin
        r_err_valid <= 1'b1;
        r_err_cause <= w_cause;
        r_err_addr  <= daddr;
      end
    end
  end

  assign err_valid = r_err_valid;
  assign err_cause = r_err_cause;
  assign err_addr  = r_err_addr;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_biu_multi.sv
// Bench for biu_multi: directed scenarios plus randomized traffic, all checked against a
// transaction-level model of decode, stall budget and error logging.
module tb_biu_multi;

  localparam int          NP  = 4;
  localparam int          DAW = 16;
  localparam logic [31:0] PB  = 32'h40000;
  localparam int          PSL = 4;
  localparam int          TO  = 16;
  localparam logic [31:0] ED  = 32'hDEADBEEF;

  logic          clk = 1'b0;
  logic          reset, dreq, err_clr;
  logic [31:0]   daddr, dwdata, drdata, daddr_m, dwdata_m, drdata_m, paddr, pwdata, err_addr;
  logic [3:0]    dwe, dwe_m, psel, pready;
  logic          dstall, err_valid;
  logic [15:0]   pwe;
  logic [127:0]  prdata;
  logic [1:0]    err_cause;
  logic [7:0]    err_count;

  int n_checks = 0;
  int n_errors = 0;

  // model state: consecutive stalled cycles of the current peripheral access
  int          m_wait = 0;
  int          m_tgt  = 0;
  bit          m_vld  = 0;
  logic [1:0]  m_cause = 0;
  logic [31:0] m_addr  = 0;
  int          m_cnt   = 0;

  logic [31:0] last_rd;
  logic        last_stall;

  logic [31:0] mem [0:255];

  always #5 clk = ~clk;

  assign drdata_m = mem[daddr_m[9:2]];
  always @(posedge clk)
    for (int b = 0; b < 4; b++)
      if (dwe_m[b]) mem[daddr_m[9:2]][8*b +: 8] <= dwdata_m[8*b +: 8];

  biu_multi #(
    .NPERIPH(NP), .DMEM_AW(DAW), .PBASE(PB), .PSPAN_LOG2(PSL), .TIMEOUT(TO), .ERR_DATA(ED)
  ) dut (
    .clk(clk), .reset(reset), .dreq(dreq), .daddr(daddr), .dwdata(dwdata), .dwe(dwe),
    .drdata(drdata), .dstall(dstall), .daddr_m(daddr_m), .dwdata_m(dwdata_m), .dwe_m(dwe_m),
    .drdata_m(drdata_m), .paddr(paddr), .pwdata(pwdata), .psel(psel), .pwe(pwe),
    .prdata(prdata), .pready(pready), .err_clr(err_clr), .err_valid(err_valid),
    .err_cause(err_cause), .err_addr(err_addr), .err_count(err_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // kind: 0 = DMEM, 1 = peripheral idx, 2 = unmapped
  function automatic void decode(input logic [31:0] a, output int kind, output int idx);
    longint unsigned la;
    la   = a;
    idx  = 0;
    kind = 2;
    if (la < (64'd1 << DAW)) kind = 0;
    else if (la >= PB && la < PB + NP * (1 << PSL)) begin
      kind = 1;
      idx  = int'((la - PB) >> PSL);
    end
  endfunction

  task automatic step();
    int kind, idx, err;
    bit rdy, abort, e_stall;
    logic [31:0] e_rd;
    logic [3:0]  e_psel, e_dwem;
    logic [15:0] e_pwe;
    @(negedge clk);
    decode(daddr, kind, idx);
    rdy     = (kind == 1) ? pready[idx] : 1'b1;
    abort   = dreq && kind == 1 && !rdy && m_wait > 0 && idx == m_tgt && m_wait == TO - 1;
    e_stall = !reset && dreq && kind == 1 && !rdy && !abort;
    e_rd    = mem[daddr[9:2]];
    if (dreq && kind == 1) e_rd = abort ? ED : prdata[32*idx +: 32];
    if (dreq && kind == 2) e_rd = ED;
    e_psel  = (dreq && kind == 1) ? 4'(1 << idx) : 4'h0;
    e_pwe   = (dreq && kind == 1) ? (16'(dwe) << (4 * idx)) : 16'h0;
    e_dwem  = (dreq && kind == 0) ? dwe : 4'h0;
    last_rd    = drdata;
    last_stall = dstall;
    check("drdata", drdata, e_rd);
    check("dstall", dstall, e_stall);
    check("psel", psel, e_psel);
    check("pwe", pwe, e_pwe);
    check("dwe_m", dwe_m, e_dwem);
    check("daddr_m", daddr_m, daddr);
    check("paddr", paddr, daddr);
    check("pwdata", pwdata, dwdata);
    check("dwdata_m", dwdata_m, dwdata);
    @(posedge clk);
    if (reset) begin
      m_wait = 0; m_vld = 0; m_cause = 0; m_addr = 0; m_cnt = 0;
    end else begin
      err = (dreq && kind == 2) ? 1 : (abort ? 2 : 0);
      if (err != 0 && m_cnt < 255) m_cnt++;
      if (err_clr) begin
        m_vld = 0; m_cause = 0; m_addr = 0;
      end else if (err != 0 && !m_vld) begin
        m_vld = 1; m_cause = 2'(err); m_addr = daddr;
      end
      if (!(dreq && kind == 1) || rdy) m_wait = 0;
      else if (m_wait == 0) begin m_wait = 1; m_tgt = idx; end
      else if (idx != m_tgt || abort) m_wait = 0;
      else m_wait++;
    end
    #1;
    check("err_valid", err_valid, m_vld);
    check("err_cause", err_cause, m_cause);
    check("err_addr", err_addr, m_addr);
    check("err_count", err_count, m_cnt);
  endtask

  task automatic drive(input bit req, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we);
    dreq = req; daddr = a; dwdata = wd; dwe = we;
  endtask

  initial begin
    int nst, kind, idx, len;
    logic [31:0] a;
    bit stuck;
    reset = 1; err_clr = 0; pready = 4'hF;
    prdata = {32'hC3C3_0003, 32'hC2C2_0002, 32'hC1C1_0001, 32'hC0C0_0000};
    drive(0, 32'h0, 32'h0, 4'h0);
    step(); step();
    reset = 0;
    step();
    check("rst_count", err_count, 0);
    check("rst_valid", err_valid, 0);

    // DMEM store then load
    drive(1, 32'h100, 32'h12345678, 4'hF); step();
    drive(1, 32'h100, 32'h0, 4'h0); step();
    check("dmem_load", last_rd, 32'h12345678);

    // peripheral 1 store / load, no wait
    drive(1, 32'h40014, 32'hCAFE0001, 4'hF); step();
    check("p1_pwe", pwe, 16'h00F0);
    drive(1, 32'h40014, 32'h0, 4'h0); step();
    check("p1_load", last_rd, 32'hC1C1_0001);

    // peripheral 2 with three wait states
    drive(1, 32'h40020, 32'h0, 4'h0);
    pready = 4'b1011; nst = 0;
    for (int k = 0; k < 3; k++) begin step(); if (last_stall) nst++; end
    pready = 4'hF; step();
    check("p2_stalls", nst, 3);
    check("p2_load", last_rd, 32'hC2C2_0002);
    check("p2_nostall", last_stall, 0);

    // peripheral 3 stuck: timeout
    drive(1, 32'h40030, 32'h0, 4'h0);
    pready = 4'b0111; nst = 0;
    for (int k = 0; k < 40; k++) begin step(); if (!last_stall) break; nst++; end
    check("to_stalls", nst, TO - 1);
    check("to_data", last_rd, ED);
    check("to_valid", err_valid, 1);
    check("to_cause", err_cause, 2'b10);
    check("to_addr", err_addr, 32'h40030);
    check("to_count", err_count, 1);
    drive(0, 32'h0, 32'h0, 4'h0); pready = 4'hF; step();

    // unmapped accesses and clear
    reset = 1; step(); reset = 0;
    drive(1, 32'h80000, 32'h0, 4'h0); step();
    check("um_data", last_rd, ED);
    drive(1, 32'h90000, 32'h55AA55AA, 4'hF); step();
    check("um_addr", err_addr, 32'h80000);
    check("um_count", err_count, 2);
    err_clr = 1; drive(1, 32'h80004, 32'h0, 4'h0); step(); err_clr = 0;
    check("clr_valid", err_valid, 0);
    check("clr_count", err_count, 3);
    for (int k = 0; k < 300; k++) begin drive(1, 32'h80000 + 32'(4 * k), 32'h0, 4'h0); step(); end
    check("sat_count", err_count, 255);

    // reset in the middle of a stall
    drive(1, 32'h40030, 32'h0, 4'h0); pready = 4'b0111;
    for (int k = 0; k < 5; k++) step();
    reset = 1; step();
    check("rst_wait_stall", last_stall, 0);
    reset = 0; drive(0, 32'h0, 32'h0, 4'h0); pready = 4'hF; step();
    check("rst_wait_count", err_count, 0);
    drive(1, 32'h200, 32'hA5A50F0F, 4'hF); step();
    drive(1, 32'h200, 32'h0, 4'h0); step();
    check("post_rst_load", last_rd, 32'hA5A50F0F);

    // randomized traffic
    for (int t = 0; t < 220; t++) begin
      kind = int'($urandom_range(0, 2));
      idx  = int'($urandom_range(0, NP - 1));
      case (kind)
        0: a = $urandom & 32'h0000FFFC;
        1: a = PB + 32'(idx * 16) + ($urandom & 32'hC);
        default: case ($urandom_range(0, 3))
          0: a = 32'h10000;
          1: a = PB + 32'(NP * 16);
          default: a = $urandom | 32'h00100000;
        endcase
      endcase
      drive(1, a, $urandom, ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom));
      stuck = ($urandom_range(0, 3) == 0);
      len   = int'($urandom_range(1, 24));
      for (int c = 0; c < len; c++) begin
        pready = 4'($urandom) | 4'($urandom);
        if (stuck) pready[idx] = 1'b0;
        prdata  = {$urandom, $urandom, $urandom, $urandom};
        err_clr = ($urandom_range(0, 15) == 0);
        reset   = ($urandom_range(0, 96) == 0);
        dreq    = ($urandom_range(0, 7) != 0);
        step();
      end
    end
    reset = 0; err_clr = 0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/biu_multi.md
Name: biu_multi

Overview:
- Parametrised bus interface unit between the single-cycle CPU data port and DMEM plus NPERIPH memory-mapped peripherals.
- Decodes each access to exactly one target and forwards write enables only to that target.
- Muxes read data back to the CPU and supports per-peripheral wait states via a ready handshake, with a timeout watchdog.
- Logs unmapped or timed-out accesses in sticky error registers.

Parameters:
- NPERIPH, 4, number of peripheral channels (1..8).
- DMEM_AW, 16, DMEM occupies byte addresses 0 .. 2^DMEM_AW-1.
- PBASE, 32'h40000, byte address of peripheral 0; must be aligned to 2^PSPAN_LOG2.
- PSPAN_LOG2, 4, each peripheral owns 2^PSPAN_LOG2 bytes, contiguous from PBASE.
- TIMEOUT, 16, maximum stall cycles before abort (2..255).
- ERR_DATA, 32'hDEADBEEF, read data returned on unmapped or aborted access.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- dreq  in  1  CPU access valid this cycle.
- daddr  in  32  CPU byte address.
- dwdata  in  32  CPU write data.
- dwe  in  4  CPU byte write enables; 0 means load.
- drdata  out  32  read data to CPU.
- dstall  out  1  CPU must hold request and stall.
- daddr_m  out  32  DMEM address.
- dwdata_m  out  32  DMEM write data.
- dwe_m  out  4  DMEM byte enables.
- drdata_m  in  32  DMEM read data.
- paddr  out  32  shared peripheral address (equals daddr).
- pwdata  out  32  shared peripheral write data.
- psel  out  NPERIPH  one-hot peripheral select.
- pwe  out  4*NPERIPH  per-channel byte enables; channel i uses bits [4i+3:4i].
- prdata  in  32*NPERIPH  per-channel read data.
- pready  in  NPERIPH  per-channel ready.
- err_clr  in  1  clears err_valid, err_cause and err_addr.
- err_valid  out  1  sticky error flag.
- err_cause  out  2  01 = unmapped, 10 = timeout.
- err_addr  out  32  address of the first logged error.
- err_count  out  8  saturating count of all errors.

Behaviour:
- Decode is combinational.
  - DMEM is selected when daddr[31:DMEM_AW] == 0.
  - Peripheral i is selected when daddr[31:PSPAN_LOG2] == (PBASE>>PSPAN_LOG2)+i.
  - Any other address is unmapped.
- Without dreq: psel = 0, pwe = 0, dwe_m = 0, dstall = 0, drdata = drdata_m.
- DMEM access:
  - daddr_m/dwdata_m always pass through; dwe_m = dwe only when DMEM is selected and dreq is high.
  - Zero added latency; never stalls.
- Peripheral i access:
  - psel[i] = 1; pwe channel i = dwe; all other channels get 0.
  - drdata = prdata[i]. The access completes in the cycle where pready[i] = 1.
  - dstall = !pready[i] & !abort.
- Unmapped access:
  - No enables asserted; drdata = ERR_DATA; dstall = 0.
  - Logs cause 01 at the clock edge.
- Watchdog FSM, states IDLE and WAIT, with an 8-bit wcnt:
  - IDLE: peripheral access with !pready → WAIT, wcnt = 1.
  - WAIT, pready → IDLE, wcnt = 0.
  - WAIT, !pready and wcnt < TIMEOUT-1 → stay in WAIT, wcnt increments.
  - WAIT, !pready and wcnt == TIMEOUT-1 → abort is high this cycle: dstall = 0, drdata = ERR_DATA, psel/pwe still driven. At the edge: cause 10 is logged, FSM → IDLE, wcnt = 0.
  - dreq dropping, or the address moving to a different target while in WAIT → IDLE, wcnt = 0, no error logged.
  - A peripheral access therefore stalls for at most TIMEOUT-1 cycles.
- Error logging:
  - On a logged error, err_count increments, saturating at 255.
  - If err_valid = 0: set err_valid = 1 and load err_cause and err_addr.
  - If err_valid = 1: err_cause and err_addr hold the first error.
  - err_clr has priority over a same-cycle error for err_valid, err_cause and err_addr, but err_count still increments.
  - err_count is cleared only by reset.
- Reset, synchronous: FSM = IDLE, wcnt = 0, err_valid = 0, err_cause = 0, err_addr = 0, err_count = 0.
  - Combinational outputs follow the inputs during reset; dstall is forced to 0 while reset is high.
  - A reset during WAIT abandons the access.

Test Plan:
- Store 32'h12345678 to 0x100 with dwe = F, then load 0x100 → dwe_m = F, pwe = 0; the load returns 32'h12345678 with dstall = 0.
- Store to 0x40014 with pready[1] = 1 → psel = 4'b0010, pwe[7:4] = F, all other pwe = 0; a load returns prdata[1] with no stall.
- Load 0x40020 with pready[2] low for 3 cycles → dstall = 1 for exactly 3 cycles, then drdata = prdata[2] and the FSM is back in IDLE.
- Load 0x40030 with pready[3] stuck at 0 → dstall = 1 for 15 cycles, then drdata = 32'hDEADBEEF with dstall = 0; next cycle err_valid = 1, err_cause = 10, err_addr = 0x40030, err_count = 1.
- Load 0x80000 (unmapped), then an unmapped store to 0x90000 → drdata = ERR_DATA, no enables asserted, err_addr stays 0x80000, err_count = 2.
  - err_clr together with a third error → err_valid = 0 and err_count = 3.
  - 300 further unmapped accesses → err_count saturates at 255.
- Assert reset during a WAIT stall → next cycle dstall = 0, all error state is zero, and a subsequent DMEM access works normally.
